// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- EX-stage multiply/divide unit holding the HI/LO register pair.
//
// Executes mult, multu, div, divu, mthi and mtlo on the forwarded EX operands.
// Multiply/divide results are computed at the accepting edge, parked in
// pending registers, and committed to HI/LO when the busy countdown expires.
// mthi/mtlo write their register at the accepting edge and never set busy.
//
// Handshake: a request on mdOp_Ex (1..6) is taken at a rising edge only when
// reset=0, mdKill_Ex=0 and busy_Ex=0. Anything presented while busy_Ex=1 is
// dropped; the ID-stage hazard logic is expected to stall instead.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   calA_Ex    in   [31:0] forwarded rs operand
//   calB_Ex    in   [31:0] forwarded rt operand
//   mdOp_Ex    in   [2:0]  0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                          5 mthi, 6 mtlo, 7 reserved (none)
//   mdKill_Ex  in   EX instruction is flushed; suppresses this cycle's op
//   busy_Ex    out  operation in progress (FSM is in RUN)
//   hi_Ex      out  [31:0] current HI
//   lo_Ex      out  [31:0] current LO
// -----------------------------------------------------------------------------
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] calA_Ex,
   input  logic [31:0] calB_Ex,
   input  logic [2:0]  mdOp_Ex,
   input  logic        mdKill_Ex,
   output logic        busy_Ex,
   output logic [31:0] hi_Ex,
   output logic [31:0] lo_Ex
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   phi_q, phi_d, plo_q, plo_d;

   // ---------------------------------------------------------------- datapath
   logic signed [63:0] smul;
   logic [63:0]        umul;
   logic signed [31:0] sdiv_a, sdiv_b, sdiv_q, sdiv_r;
   logic [31:0]        udiv_b, udiv_q, udiv_r;
   logic               div_zero, div_ovf;
   logic [31:0]        res_hi, res_lo;

   assign smul = $signed({{32{calA_Ex[31]}}, calA_Ex}) * $signed({{32{calB_Ex[31]}}, calB_Ex});
   assign umul = {32'd0, calA_Ex} * {32'd0, calB_Ex};

   assign div_zero = (calB_Ex == 32'd0);
   assign div_ovf  = (calA_Ex == 32'h8000_0000) && (calB_Ex == 32'hFFFF_FFFF);

   // The divider never sees the two special cases; they are resolved in the
   // result mux, so a benign divisor of 1 keeps the operators well-defined.
   assign sdiv_a = $signed(calA_Ex);
   assign sdiv_b = (div_zero || div_ovf) ? 32'sd1 : $signed(calB_Ex);
   assign sdiv_q = sdiv_a / sdiv_b;
   assign sdiv_r = sdiv_a % sdiv_b;
   assign udiv_b = div_zero ? 32'd1 : calB_Ex;
   assign udiv_q = calA_Ex / udiv_b;
   assign udiv_r = calA_Ex % udiv_b;

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (mdOp_Ex)
         3'd1: begin
            res_hi = smul[63:32];
            res_lo = smul[31:0];
         end
         3'd2: begin
            res_hi = umul[63:32];
            res_lo = umul[31:0];
         end
         3'd3: begin
            if (div_zero) begin
               res_hi = calA_Ex;
               res_lo = 32'hFFFF_FFFF;
            end else if (div_ovf) begin
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = sdiv_r;
               res_lo = sdiv_q;
            end
         end
         3'd4: begin
            if (div_zero) begin
               res_hi = calA_Ex;
               res_lo = 32'hFFFF_FFFF;
            end else begin
               res_hi = udiv_r;
               res_lo = udiv_q;
            end
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

   // ------------------------------------------------------------- next state
   logic accept;
   assign accept = !mdKill_Ex && (state_q == S_IDLE) &&
                   (mdOp_Ex >= 3'd1) && (mdOp_Ex <= 3'd6);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (mdOp_Ex)
                  3'd1, 3'd2: begin
                     state_d = S_RUN;
                     cnt_d   = CW'(MULT_CYCLES);
                     phi_d   = res_hi;
                     plo_d   = res_lo;
                  end
                  3'd3, 3'd4: begin
                     state_d = S_RUN;
                     cnt_d   = CW'(DIV_CYCLES);
                     phi_d   = res_hi;
                     plo_d   = res_lo;
                  end
                  3'd5:    hi_d = calA_Ex;
                  3'd6:    lo_d = calA_Ex;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_RUN: begin
            // Requests and kills are ignored here: the issuing instruction
            // has already left EX, so its result is always committed.
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               hi_d    = phi_q;
               lo_d    = plo_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end

   assign busy_Ex = (state_q == S_RUN);
   assign hi_Ex   = hi_q;
   assign lo_Ex   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- EX-stage multiply/divide unit with its HI/LO register pair.
- Consumes the forwarded EX operands calA_Ex/calB_Ex and executes mult, multu, div, divu, mthi and mtlo.
- Holds HI/LO and exposes a busy flag. The hazard logic uses busy to stall later mult/div/mfhi/mflo/mthi/mtlo in ID.
- Supports EX-stage kill, so a flushed instruction never starts an operation or writes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be 1 or more).
- DIV_CYCLES, 10, busy cycles for div/divu (must be 1 or more).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- calA_Ex  input  32  forwarded rs operand.
- calB_Ex  input  32  forwarded rt operand.
- mdOp_Ex  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- mdKill_Ex  input  1  the EX instruction is being flushed (exception or interrupt); suppresses this cycle's mdOp_Ex.
- busy_Ex  output  1  an operation is in progress.
- hi_Ex  output  32  current HI register.
- lo_Ex  output  32  current LO register.

Behaviour:
- Clocking: all state updates on the rising edge of clk. reset has priority over everything else.
- Reset values: HI=0, LO=0, busy_Ex=0, cycle counter=0, pending-result registers=0.
- A request is accepted at an edge when all of the following hold: reset=0, mdKill_Ex=0, busy_Ex=0 and mdOp_Ex is 1..6.
- If mdKill_Ex=1, the operation is a no-op: no state changes.
- State machine, two states:
  - IDLE: busy_Ex=0.
  - RUN: busy_Ex=1.
  - IDLE to RUN: an accepted op 1..4. At that edge, load the counter with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4) and capture the result into the pending HI/LO registers.
  - RUN: the counter decrements every edge.
  - RUN to IDLE: at the edge where the counter equals 1, copy pending HI/LO into HI/LO and clear busy.
- Latency: busy_Ex is high for exactly N cycles after the accepting edge. New HI/LO are visible in the first cycle busy_Ex=0.
- HI/LO never change while busy_Ex=1.
- mthi/mtlo (ops 5, 6): when accepted, write calA_Ex into HI or LO at that edge. No busy cycles. The other register is unchanged.
- Arithmetic:
  - mult: 64-bit signed product of calA_Ex and calB_Ex. HI = bits 63:32, LO = bits 31:0.
  - multu: same as mult, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient (LO) and remainder (HI).
- Divide by zero (div or divu, calB_Ex=0): LO=32'hFFFFFFFF, HI=calA_Ex.
- Signed overflow (div with 32'h80000000 / 32'hFFFFFFFF): LO=32'h80000000, HI=0.
- Request while busy_Ex=1: ignored, no state change. Upstream stalling makes this illegal; the bench flags it as an assertion error.
- mdKill_Ex while busy_Ex=1 does not abort the running operation. The issuing instruction has already passed EX, so the result is committed normally.
- reset mid-RUN: the operation is aborted and all state returns to reset values at that edge.
- Operands are sampled only at the accepting edge. Later changes on calA_Ex/calB_Ex do not affect the pending result.

Test Plan:
- Reset, then mult with calA=32'hFFFFFFFE (-2), calB=3 -> busy_Ex high for exactly 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA. HI/LO hold 0 during busy.
- multu with calA=calB=32'hFFFFFFFF -> after 5 busy cycles, HI=32'hFFFFFFFE, LO=32'h00000001.
- div with calA=-7, calB=2 -> busy for 10 cycles; LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). divu with calA=7, calB=0 -> LO=32'hFFFFFFFF, HI=7.
- mthi with calA=32'h12345678, then mtlo with calA=32'hCAFEBABE on consecutive cycles -> each visible the next cycle, busy_Ex never asserts. mult presented with mdKill_Ex=1 -> busy stays 0, HI/LO unchanged.
- Start div, assert mdKill_Ex and change calA/calB in cycle 3 of RUN -> result still committed after 10 cycles and matches the captured operands. Assert reset in cycle 4 of a second div -> busy_Ex=0, HI=LO=0 the next cycle.
- Signed overflow div 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0. A request issued while busy is ignored and raises a bench assertion.
